// File: rtl/core_pkg.sv
// Shared RV32I constants for the core: major opcodes, sequencer state
// encodings and trap cause codes. Decoder, datapath and sequencer all import this.
package core_pkg;

    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_IMM      = 7'b0010011;
    localparam logic [6:0] OP_OP       = 7'b0110011;
    localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_MEM       = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_HALT      = 3'd6,
        ST_TRAP      = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_ILLEGAL       = 2'd0,
        CAUSE_SYSTEM        = 2'd1,
        CAUSE_DATA_TIMEOUT  = 2'd2,
        CAUSE_FETCH_TIMEOUT = 2'd3
    } trap_cause_t;

    // SYSTEM is deliberately excluded: it is trapped separately with its own cause.
    function automatic logic is_rv32i_opcode(input logic [6:0] op);
        return op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
                          OP_LOAD, OP_STORE, OP_IMM, OP_OP, OP_MISC_MEM};
    endfunction

    function automatic logic is_mem_opcode(input logic [6:0] op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

    function automatic logic writes_rd(input logic [6:0] op);
        return !(op inside {OP_STORE, OP_BRANCH, OP_MISC_MEM});
    endfunction

endpackage

// File: rtl/core_sequencer_if.sv
// Instruction and data memory handshake bundle between the sequencer (master)
// and the memory subsystem (slave).
interface core_sequencer_if;

    // A request is held high for the whole waiting state; the transfer completes
    // on the rising edge where ready is sampled high. Ready is ignored whenever
    // the matching request is low, and req never depends combinationally on ready.
    logic        imem_req;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ready;

    modport master (
        output imem_req,
        input  imem_ready,
        input  imem_rdata,
        output dmem_req,
        output dmem_we,
        input  dmem_ready
    );

    modport slave (
        input  imem_req,
        output imem_ready,
        output imem_rdata,
        input  dmem_req,
        input  dmem_we,
        output dmem_ready
    );

endinterface

// File: rtl/bus_timeout_counter.sv
// Wait-cycle counter shared by the fetch and data-access states. Expires in the
// cycle the count would reach TIMEOUT_CYCLES while still enabled; 0 disables it.
module bus_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_en && (count != LAST)) begin
            count <= count + 1'b1;
        end
    end

    // A ready in the expiring cycle drops count_en, so ready always wins.
    assign expired = (TIMEOUT_CYCLES != 0) && count_en && (count == LAST);

endmodule

// File: rtl/core_sequencer.sv
// Multicycle control FSM for the RV32I core: fetch, decode check, execute,
// memory access and writeback, with halt support and a sticky trap.
module core_sequencer
    import core_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    core_sequencer_if.master        bus,
    output logic [31:0]             instruction,
    input  logic                    instruction_invalid,
    input  logic [6:0]              opcode,
    input  logic                    branch_taken,
    output logic                    rf_we,
    output logic                    pc_we,
    output logic                    pc_sel,
    input  logic                    halt_req,
    output logic                    halted,
    output logic                    trap,
    output logic [1:0]              trap_cause,
    output logic [31:0]             retire_count,
    output logic [2:0]              state
);

    state_t      state_q, state_d;
    trap_cause_t cause_q, cause_d;
    logic        cause_load;
    logic [6:0]  op_q;
    logic [31:0] instruction_q;
    logic [31:0] retire_q;
    logic        waiting;
    logic        ready_now;
    logic        tmo_clear;
    logic        tmo_count_en;
    logic        tmo_expired;

    assign waiting      = (state_q == ST_FETCH) || (state_q == ST_MEM);
    assign ready_now    = (state_q == ST_FETCH) ? bus.imem_ready : bus.dmem_ready;
    assign tmo_clear    = !waiting;
    assign tmo_count_en = waiting && !ready_now;

    bus_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (tmo_clear),
        .count_en(tmo_count_en),
        .expired (tmo_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cause_d    = CAUSE_ILLEGAL;
        cause_load = 1'b0;
        case (state_q)
            ST_IDLE: state_d = ST_FETCH;
            ST_FETCH: begin
                if (bus.imem_ready) begin
                    state_d = ST_DECODE;
                end else if (tmo_expired) begin
                    state_d    = ST_TRAP;
                    cause_d    = CAUSE_FETCH_TIMEOUT;
                    cause_load = 1'b1;
                end
            end
            ST_DECODE: begin
                if (instruction_invalid) begin
                    state_d    = ST_TRAP;
                    cause_d    = CAUSE_ILLEGAL;
                    cause_load = 1'b1;
                end else if (opcode == OP_SYSTEM) begin
                    state_d    = ST_TRAP;
                    cause_d    = CAUSE_SYSTEM;
                    cause_load = 1'b1;
                end else if (!is_rv32i_opcode(opcode)) begin
                    state_d    = ST_TRAP;
                    cause_d    = CAUSE_ILLEGAL;
                    cause_load = 1'b1;
                end else begin
                    state_d = ST_EXECUTE;
                end
            end
            ST_EXECUTE: state_d = is_mem_opcode(op_q) ? ST_MEM : ST_WRITEBACK;
            ST_MEM: begin
                if (bus.dmem_ready) begin
                    state_d = ST_WRITEBACK;
                end else if (tmo_expired) begin
                    state_d    = ST_TRAP;
                    cause_d    = CAUSE_DATA_TIMEOUT;
                    cause_load = 1'b1;
                end
            end
            ST_WRITEBACK: state_d = halt_req ? ST_HALT : ST_FETCH;
            ST_HALT:      state_d = halt_req ? ST_HALT : ST_FETCH;
            ST_TRAP:      state_d = ST_TRAP;
            default:      state_d = ST_IDLE;
        endcase
    end

    // Moore outputs: only the state, the opcode latched in DECODE and
    // branch_taken (in WRITEBACK) reach the control outputs.
    always_comb begin
        bus.imem_req = 1'b0;
        bus.dmem_req = 1'b0;
        bus.dmem_we  = 1'b0;
        rf_we        = 1'b0;
        pc_we        = 1'b0;
        pc_sel       = 1'b0;
        halted       = 1'b0;
        trap         = 1'b0;
        case (state_q)
            ST_FETCH: bus.imem_req = 1'b1;
            ST_MEM: begin
                bus.dmem_req = 1'b1;
                bus.dmem_we  = (op_q == OP_STORE);
            end
            ST_WRITEBACK: begin
                pc_we = 1'b1;
                rf_we = writes_rd(op_q);
                case (op_q)
                    OP_JAL, OP_JALR: pc_sel = 1'b1;
                    OP_BRANCH:       pc_sel = branch_taken;
                    default:         pc_sel = 1'b0;
                endcase
            end
            ST_HALT: halted = 1'b1;
            ST_TRAP: trap   = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instruction_q <= '0;
            op_q          <= '0;
            cause_q       <= CAUSE_ILLEGAL;
            retire_q      <= '0;
        end else begin
            if ((state_q == ST_FETCH) && bus.imem_ready) begin
                instruction_q <= bus.imem_rdata;
            end
            if (state_q == ST_DECODE) begin
                op_q <= opcode;
            end
            if (cause_load) begin
                cause_q <= cause_d;
            end
            if (state_q == ST_WRITEBACK) begin
                retire_q <= retire_q + 32'd1;
            end
        end
    end

    assign instruction  = instruction_q;
    assign trap_cause   = cause_q;
    assign retire_count = retire_q;
    assign state        = state_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Randomized bench for core_sequencer: a driver plays the memories, a decoder
// stub feeds opcode back, and a monitor scores retire/trap events against a model.
module tb_core_sequencer;

    localparam int TMO = 4;

    localparam logic [6:0] T_LUI    = 7'b0110111;
    localparam logic [6:0] T_AUIPC  = 7'b0010111;
    localparam logic [6:0] T_JAL    = 7'b1101111;
    localparam logic [6:0] T_JALR   = 7'b1100111;
    localparam logic [6:0] T_BRANCH = 7'b1100011;
    localparam logic [6:0] T_LOAD   = 7'b0000011;
    localparam logic [6:0] T_STORE  = 7'b0100011;
    localparam logic [6:0] T_IMM    = 7'b0010011;
    localparam logic [6:0] T_OP     = 7'b0110011;
    localparam logic [6:0] T_FENCE  = 7'b0001111;
    localparam logic [6:0] T_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic        is_trap;
        logic [1:0]  cause;
        logic        rf_we;
        logic        pc_sel;
        logic        dmem_we;
        logic [7:0]  dmem_cycles;
        logic [7:0]  latency;
        logic [31:0] retire;
        logic [31:0] instr;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] instruction;
    logic        instruction_invalid;
    logic [6:0]  opcode;
    logic        branch_taken;
    logic        rf_we;
    logic        pc_we;
    logic        pc_sel;
    logic        halt_req;
    logic        halted;
    logic        trap;
    logic [1:0]  trap_cause;
    logic [31:0] retire_count;
    logic [2:0]  state;
    logic        hide_invalid;
    logic        dec_known;

    exp_t exp_q[$];
    int   checks;
    int   failures;
    int   model_retired;
    int   cyc;

    core_sequencer_if bus_if ();

    core_sequencer #(
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .bus                (bus_if),
        .instruction        (instruction),
        .instruction_invalid(instruction_invalid),
        .opcode             (opcode),
        .branch_taken       (branch_taken),
        .rf_we              (rf_we),
        .pc_we              (pc_we),
        .pc_sel             (pc_sel),
        .halt_req           (halt_req),
        .halted             (halted),
        .trap               (trap),
        .trap_cause         (trap_cause),
        .retire_count       (retire_count),
        .state              (state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // decoder stub; hide_invalid exercises the sequencer's own opcode-set check
    always_comb begin
        dec_known = 1'b0;
        case (instruction[6:0])
            T_LUI, T_AUIPC, T_JAL, T_JALR, T_BRANCH, T_LOAD, T_STORE,
            T_IMM, T_OP, T_FENCE, T_SYSTEM: dec_known = 1'b1;
            default: ;
        endcase
        opcode              = dec_known ? instruction[6:0] : 7'd0;
        instruction_invalid = !dec_known && !hide_invalid;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        failures++;
        $display("FAIL %s at %0t", nm, $time);
    endtask

    // reference model: outcome of one instruction from its opcode and wait counts
    function automatic logic rv32i_op(input logic [6:0] op);
        return op == T_LUI || op == T_AUIPC || op == T_JAL || op == T_JALR ||
               op == T_BRANCH || op == T_LOAD || op == T_STORE || op == T_IMM ||
               op == T_OP || op == T_FENCE;
    endfunction

    function automatic exp_t model(input logic [31:0] instr, input int iw, input int dw,
                                   input logic bt);
        exp_t e;
        logic [6:0] op;
        logic mem;
        e = '0;
        e.instr = instr;
        e.retire = model_retired;
        op = instr[6:0];
        mem = (op == T_LOAD) || (op == T_STORE);
        if (iw >= TMO) begin
            e.is_trap = 1'b1; e.cause = 2'd3; e.latency = 8'(TMO + 1);
        end else if (op == T_SYSTEM) begin
            e.is_trap = 1'b1; e.cause = 2'd1; e.latency = 8'(iw + 3);
        end else if (!rv32i_op(op)) begin
            e.is_trap = 1'b1; e.cause = 2'd0; e.latency = 8'(iw + 3);
        end else if (mem && dw >= TMO) begin
            e.is_trap = 1'b1; e.cause = 2'd2; e.latency = 8'(iw + TMO + 4);
        end else begin
            e.latency     = 8'(iw + 4 + (mem ? dw + 1 : 0));
            e.dmem_cycles = mem ? 8'(dw + 1) : 8'd0;
            e.dmem_we     = (op == T_STORE);
            e.rf_we       = !(op == T_STORE || op == T_BRANCH || op == T_FENCE);
            e.pc_sel      = (op == T_JAL || op == T_JALR) ? 1'b1 :
                            (op == T_BRANCH) ? bt : 1'b0;
        end
        return e;
    endfunction

    // monitor / scoreboard
    initial begin
        logic prev_req, prev_trap, dm_we_seen;
        int start_cyc, dm_cnt;
        exp_t e;
        prev_req = 0; prev_trap = 0; dm_we_seen = 0; start_cyc = 0; dm_cnt = 0; cyc = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_req = 0; prev_trap = 0; dm_cnt = 0; dm_we_seen = 0;
            end else begin
                cyc++;
                if (bus_if.imem_req && !prev_req) begin
                    start_cyc = cyc; dm_cnt = 0; dm_we_seen = 0;
                end
                if (bus_if.dmem_req) begin
                    dm_cnt++;
                    if (bus_if.dmem_we) dm_we_seen = 1;
                end
                if (pc_we) begin
                    if (exp_q.size() == 0) fail_now("unexpected_retire");
                    else begin
                        e = exp_q.pop_front();
                        checks++;
                        if (e.is_trap) begin
                            failures++;
                            $display("FAIL event_kind actual=retire expected=trap cause %0d instr=0x%0h", e.cause, e.instr);
                        end
                        chk("rf_we", rf_we, e.rf_we);
                        chk("pc_sel", pc_sel, e.pc_sel);
                        chk("latency", cyc - start_cyc + 1, e.latency);
                        chk("dmem_cycles", dm_cnt, e.dmem_cycles);
                        chk("dmem_we", dm_we_seen, e.dmem_we);
                        chk("retire_count", retire_count, e.retire);
                        chk("instruction", instruction, e.instr);
                    end
                end
                if (trap && !prev_trap) begin
                    if (exp_q.size() == 0) fail_now("unexpected_trap");
                    else begin
                        e = exp_q.pop_front();
                        checks++;
                        if (!e.is_trap) begin
                            failures++;
                            $display("FAIL event_kind actual=trap expected=retire instr=0x%0h", e.instr);
                        end
                        chk("trap_cause", trap_cause, e.cause);
                        chk("trap_latency", cyc - start_cyc + 1, e.latency);
                        chk("trap_retire_count", retire_count, e.retire);
                    end
                end
                if (trap) chk("trap_quiet", {bus_if.imem_req, bus_if.dmem_req, pc_we, rf_we}, 0);
                prev_req  = bus_if.imem_req;
                prev_trap = trap;
            end
        end
    end

    // driver tasks
    task automatic reset_checks();
        chk("rst_ctrl", {bus_if.imem_req, bus_if.dmem_req, bus_if.dmem_we, rf_we, pc_we,
                         pc_sel, halted, trap, trap_cause}, 0);
        chk("rst_state", state, 0);
        chk("rst_instruction", instruction, 0);
        chk("rst_retire", retire_count, 0);
    endtask

    task automatic release_reset();
        exp_q.delete();
        model_retired = 0;
        halt_req = 0;
        bus_if.imem_ready = 0;
        bus_if.dmem_ready = 0;
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        chk("first_fetch", bus_if.imem_req, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        #1;
        reset_checks();
        release_reset();
    endtask

    task automatic wait_imem_req(output logic ok);
        int n;
        n = 0;
        while (!bus_if.imem_req && n < 50) begin @(negedge clk); n++; end
        ok = bus_if.imem_req;
    endtask

    task automatic run_instr(input logic [31:0] instr, input int iw, input int dw,
                             input logic bt, input logic hlt, input logic hide);
        exp_t e;
        int n;
        logic ok, is_mem;
        e = model(instr, iw, dw, bt);
        exp_q.push_back(e);
        if (!e.is_trap) model_retired++;
        is_mem = (instr[6:0] == T_LOAD || instr[6:0] == T_STORE) &&
                 (!e.is_trap || e.cause == 2'd2);
        wait_imem_req(ok);
        if (!ok) begin fail_now("fetch_start_timeout"); do_reset(); return; end
        branch_taken = bt;
        hide_invalid = hide;
        for (int k = 0; k < iw && k < TMO; k++) begin
            bus_if.dmem_ready = 1'($urandom_range(0, 1));
            bus_if.imem_rdata = $urandom;
            @(negedge clk);
        end
        bus_if.dmem_ready = 0;
        if (iw < TMO) begin
            bus_if.imem_ready = 1;
            bus_if.imem_rdata = instr;
            @(negedge clk);
            bus_if.imem_ready = 0;
            bus_if.imem_rdata = $urandom;
        end
        if (hlt) halt_req = 1;
        if (is_mem) begin
            n = 0;
            while (!bus_if.dmem_req && n < 50) begin @(negedge clk); n++; end
            if (!bus_if.dmem_req) begin fail_now("dmem_req_timeout"); do_reset(); return; end
            for (int k = 0; k < dw && k < TMO; k++) begin
                bus_if.imem_ready = 1'($urandom_range(0, 1));
                bus_if.imem_rdata = $urandom;
                @(negedge clk);
            end
            bus_if.imem_ready = 0;
            if (dw < TMO) begin
                bus_if.dmem_ready = 1;
                @(negedge clk);
                bus_if.dmem_ready = 0;
            end
        end
        n = 0;
        while (!pc_we && !trap && n < 50) begin @(negedge clk); n++; end
        if (trap) begin
            repeat (3) @(negedge clk);
            do_reset();
        end else if (!pc_we) begin
            fail_now("completion_timeout");
            do_reset();
        end else if (hlt) begin
            @(negedge clk);
            chk("halt_enter", halted, 1);
            chk("halt_no_fetch", bus_if.imem_req, 0);
            repeat (2) @(negedge clk);
            chk("halt_hold", halted, 1);
            halt_req = 0;
            @(negedge clk);
            chk("halt_exit", {halted, bus_if.imem_req}, 2'b01);
        end
    endtask

    task automatic mid_mem_reset();
        logic ok;
        wait_imem_req(ok);
        if (!ok) begin fail_now("fetch_start_timeout"); do_reset(); return; end
        bus_if.imem_ready = 1;
        bus_if.imem_rdata = 32'h0000A103;
        @(negedge clk);
        bus_if.imem_ready = 0;
        repeat (3) @(negedge clk);
        chk("mid_mem_req", bus_if.dmem_req, 1);
        #2;
        rst = 1;
        #1;
        chk("mid_mem_reset_outputs", {bus_if.dmem_req, pc_we, rf_we, state}, 0);
        chk("mid_mem_reset_retire", retire_count, 0);
        release_reset();
    endtask

    function automatic logic [6:0] pick_op(input int idx);
        case (idx)
            0: return T_LUI;    1: return T_AUIPC;  2: return T_JAL;
            3: return T_JALR;   4: return T_BRANCH; 5: return T_LOAD;
            6: return T_STORE;  7: return T_IMM;    8: return T_OP;
            9: return T_FENCE;  10: return T_SYSTEM;
            11: return 7'b1111111;
            default: return 7'b0101011;
        endcase
    endfunction

    initial begin
        logic [31:0] r;
        int iw, dw;
        checks = 0; failures = 0; model_retired = 0;
        rst = 0; halt_req = 0; branch_taken = 0; hide_invalid = 0;
        bus_if.imem_ready = 0; bus_if.imem_rdata = 0; bus_if.dmem_ready = 0;
        #1 rst = 1;
        #2;
        reset_checks();
        release_reset();

        run_instr(32'h00500093, 0, 0, 0, 0, 0);  // ADDI
        run_instr(32'h0000A103, 0, 3, 0, 0, 0);  // LW, 3 wait cycles
        run_instr(32'h00208063, 0, 0, 1, 0, 0);  // BEQ taken
        run_instr(32'h00208063, 0, 0, 0, 0, 0);  // BEQ not taken
        run_instr(32'h0020A023, 1, 2, 0, 0, 0);  // SW
        run_instr(32'h008000EF, 0, 0, 0, 0, 0);  // JAL
        run_instr(32'h000080E7, 2, 0, 0, 0, 0);  // JALR
        run_instr(32'h123450B7, 0, 0, 1, 0, 0);  // LUI
        run_instr(32'h00001097, 0, 0, 0, 0, 0);  // AUIPC
        run_instr(32'h0FF0000F, 0, 0, 0, 0, 0);  // FENCE
        run_instr(32'h002081B3, 0, 0, 0, 1, 0);  // ADD then halt
        run_instr(32'h00500093, 3, 0, 0, 0, 0);  // ready on the last allowed cycle
        mid_mem_reset();
        run_instr(32'h00500093, 0, 0, 0, 0, 0);
        run_instr(32'h00000000, 0, 0, 0, 0, 0);  // illegal
        run_instr(32'h00000073, 0, 0, 0, 0, 0);  // ECALL
        run_instr(32'h00500093, 4, 0, 0, 0, 0);  // fetch timeout
        run_instr(32'h0000A103, 1, 4, 0, 0, 0);  // data timeout
        run_instr(32'h0000002B, 0, 0, 0, 0, 1);  // unknown opcode, invalid not flagged

        for (int i = 0; i < 40; i++) begin
            r  = $urandom;
            iw = ($urandom_range(0, 15) == 0) ? 4 : $urandom_range(0, 3);
            dw = ($urandom_range(0, 15) == 0) ? 4 : $urandom_range(0, 3);
            run_instr({r[31:7], pick_op($urandom_range(0, 12))}, iw, dw,
                      1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0,
                      1'($urandom_range(0, 1)));
        end

        @(negedge clk);
        chk("final_retire", retire_count, model_retired);
        chk("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        failures++;
        $display("FAIL watchdog expired at %0t", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
